// File: rtl/sysid_ext_if.sv
// Avalon-MM slave bus bundle for the system-ID / uptime block.
interface sysid_ext_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        irq;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid, irq
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid, irq
  );
endinterface

// File: rtl/sysid_ext.sv
// System ID / build timestamp / scratch register block with an optional
// prescaled 64-bit uptime counter and alarm interrupt.
// Optional feature: define SYSID_UPTIME_EN to build the prescaler, uptime
// counter, high-word shadow and alarm logic.
module sysid_ext #(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int unsigned PRESCALE_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  sysid_ext_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned NB = DW / 8;

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [DW-1:0] CAPS = {16'(PRESCALE_DIV), 15'b0, UPTIME_PRESENT};

  // Byte-lane merge of write data into a register value.
  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] wd,
                                                input logic [NB-1:0] be);
    logic [DW-1:0] res;
    res = cur;
    for (int i = 0; i < int'(NB); i++) begin
      if (be[i]) res[i*8 +: 8] = wd[i*8 +: 8];
    end
    return res;
  endfunction

  logic          wr_scratch;
  logic          wr_status;
  logic [DW-1:0] scratch;
  logic          pending;
  logic          irq_en;
  logic          pending_nxt;
  logic          irq_en_nxt;
  logic          alarm_hit;
  logic [DW-1:0] up_lo;
  logic [DW-1:0] up_hi_shadow;
  logic [DW-1:0] alarm_val;
  logic [DW-1:0] rd_mux;

  assign wr_scratch = bus.write && (bus.address == 3'd4);
  assign wr_status  = bus.write && (bus.address == 3'd7);

`ifdef SYSID_UPTIME_EN
  logic [15:0]   prescaler;
  logic [63:0]   uptime;
  logic [DW-1:0] shadow;
  logic [DW-1:0] alarm;
  logic          tick;
  logic          wr_alarm;
  logic          rd_lo;

  assign tick      = (prescaler == 16'(PRESCALE_DIV - 1));
  assign wr_alarm  = bus.write && (bus.address == 3'd6);
  assign rd_lo     = bus.read && (bus.address == 3'd2);
  // Match is against the low word as it will be after this tick.
  assign alarm_hit = tick && ((uptime[DW-1:0] + 32'd1) == alarm);

  // Prescaler, uptime counter, high-word shadow and alarm register.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      uptime    <= '0;
      shadow    <= '0;
      alarm     <= '0;
    end else begin
      if (tick) begin
        prescaler <= '0;
        uptime    <= uptime + 64'd1;
      end else begin
        prescaler <= prescaler + 16'd1;
      end
      // Shadow captures the high half coherently with the low-word read.
      if (rd_lo)    shadow <= uptime[63:32];
      if (wr_alarm) alarm  <= merge_lanes(alarm, bus.writedata, bus.byteenable);
    end
  end

  assign up_lo        = uptime[DW-1:0];
  assign up_hi_shadow = shadow;
  assign alarm_val    = alarm;
`else
  assign alarm_hit    = 1'b0;
  assign up_lo        = '0;
  assign up_hi_shadow = '0;
  assign alarm_val    = '0;
`endif

  // Read data select, using register values from before this edge's write.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0: rd_mux = SYSTEM_ID;
      3'd1: rd_mux = TIMESTAMP;
      3'd2: rd_mux = up_lo;
      3'd3: rd_mux = up_hi_shadow;
      3'd4: rd_mux = scratch;
      3'd5: rd_mux = CAPS;
      3'd6: rd_mux = alarm_val;
      3'd7: rd_mux = {30'b0, irq_en, pending};
    endcase
  end

  // Pending / irq-enable next state; an alarm set beats a same-cycle clear.
  always_comb begin
    pending_nxt = pending;
    irq_en_nxt  = irq_en;
    if (wr_status) begin
      irq_en_nxt = bus.writedata[1];
      if (bus.writedata[0]) pending_nxt = 1'b0;
    end
    if (alarm_hit) pending_nxt = 1'b1;
  end

  // Bus response, scratch register and interrupt state.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
      bus.irq           <= 1'b0;
      scratch           <= '0;
      pending           <= 1'b0;
      irq_en            <= 1'b0;
    end else begin
      bus.readdatavalid <= bus.read;
      if (bus.read) bus.readdata <= rd_mux;
      if (wr_scratch) scratch <= merge_lanes(scratch, bus.writedata, bus.byteenable);
      pending <= pending_nxt;
      irq_en  <= irq_en_nxt;
      bus.irq <= pending_nxt & irq_en_nxt;
    end
  end

endmodule

// File: tb/tb_sysid_ext.sv
// Self-checking bench for sysid_ext: register map, byte lanes, read/write
// collisions, back-to-back reads, reset handling and (with SYSID_UPTIME_EN)
// uptime/shadow/alarm behaviour.
module tb_sysid_ext;

  localparam logic [31:0] SYS_ID = 32'h2013_1107;
  localparam logic [31:0] TSTAMP = 32'h5F3A_1C00;
`ifdef SYSID_UPTIME_EN
  localparam int unsigned DIV     = 4;
  localparam logic        PRESENT = 1'b1;
`else
  localparam int unsigned DIV     = 1;
  localparam logic        PRESENT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  sysid_ext_if bus();

  sysid_ext #(
    .SYSTEM_ID   (SYS_ID),
    .TIMESTAMP   (TSTAMP),
    .PRESCALE_DIV(DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model state
  logic [31:0] m_scratch;
  logic        m_irq_en;
  logic [31:0] caps_exp;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return SYS_ID;
      3'd1:    return TSTAMP;
      3'd4:    return m_scratch;
      3'd5:    return caps_exp;
      3'd7:    return {30'b0, m_irq_en, 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    if (a == 3'd4) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_scratch[b*8 +: 8] = d[b*8 +: 8];
    end else if (a == 3'd7) begin
      m_irq_en = d[1];
    end
  endtask

  task automatic bus_idle();
    bus.address    = 3'd0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = 32'h0;
    bus.byteenable = 4'h0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic apply_reset();
    @(negedge clock);
    bus_idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_scratch = 32'h0;
    m_irq_en  = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] data, output logic valid);
    bus.address = a;
    bus.read    = 1'b1;
    @(posedge clock);
    #1;
    valid = bus.readdatavalid;
    data  = bus.readdata;
    @(negedge clock);
    bus.read = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address    = a;
    bus.write      = 1'b1;
    bus.writedata  = d;
    bus.byteenable = be;
    @(negedge clock);
    bus.write = 1'b0;
    model_write(a, d, be);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdv: got %b want 0", bus.readdatavalid);
    end
    n_tests++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.readdata);
    end
    n_tests++;
    if (bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b want 0", bus.irq);
    end
  endtask

  task automatic test_id_regs();
    logic [31:0] d;
    logic        v;
    logic [2:0]  addrs [3] = '{3'd0, 3'd1, 3'd5};
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], d, v);
      n_tests++;
      if (v !== 1'b1 || d !== model_read(addrs[i])) begin
        n_fail++;
        $display("FAIL id_read[%0d]: got v=%b d=%h want v=1 d=%h", addrs[i], v, d, model_read(addrs[i]));
      end
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL rdv_single_pulse: got %b want 0", bus.readdatavalid);
    end
    @(negedge clock);
  endtask

  task automatic test_scratch_lanes();
    logic [31:0] d;
    logic        v;
    do_write(3'd4, 32'hFFFF_FFFF, 4'hF);
    do_write(3'd4, 32'h0000_0000, 4'b0101);
    do_read(3'd4, d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 32'hFF00_FF00) begin
      n_fail++; $display("FAIL scratch_be0101: got %h want ff00ff00", d);
    end
    do_write(3'd4, 32'h1234_5678, 4'h0);
    do_write(3'd5, 32'hDEAD_BEEF, 4'hF);
    do_read(3'd4, d, v);
    n_tests++;
    if (d !== 32'hFF00_FF00) begin
      n_fail++; $display("FAIL scratch_be0000: got %h want ff00ff00", d);
    end
    do_read(3'd5, d, v);
    n_tests++;
    if (d !== caps_exp) begin
      n_fail++; $display("FAIL caps_ro: got %h want %h", d, caps_exp);
    end
  endtask

  task automatic test_random();
    logic        rd, wr;
    logic [2:0]  a;
    logic [31:0] wd, exp;
    logic [3:0]  be;
    for (int i = 0; i < 300; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
`ifdef SYSID_UPTIME_EN
      if (a == 3'd2 || a == 3'd3 || a == 3'd6) a = 3'd4;
`endif
      wd  = $urandom;
      wd[0] = 1'b0;
      be  = (a == 3'd7) ? 4'hF : 4'($urandom_range(0, 15));
      exp = model_read(a);
      bus.address    = a;
      bus.read       = rd;
      bus.write      = wr;
      bus.writedata  = wd;
      bus.byteenable = be;
      @(posedge clock);
      #1;
      if (wr) model_write(a, wd, be);
      n_tests++;
      if (bus.readdatavalid !== rd) begin
        n_fail++; $display("FAIL rand_rdv[%0d]: got %b want %b", i, bus.readdatavalid, rd);
      end
      if (rd) begin
        n_tests++;
        if (bus.readdata !== exp) begin
          n_fail++; $display("FAIL rand_rdata[%0d] addr %0d: got %h want %h", i, a, bus.readdata, exp);
        end
      end
      n_tests++;
      if (bus.irq !== 1'b0) begin
        n_fail++; $display("FAIL rand_irq[%0d]: got %b want 0", i, bus.irq);
      end
      @(negedge clock);
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [5] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd4};
    bus.read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.address = seq[i];
      @(posedge clock);
      #1;
      n_tests++;
      if (bus.readdatavalid !== 1'b1 || bus.readdata !== model_read(seq[i])) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.readdatavalid, bus.readdata, model_read(seq[i]));
      end
      @(negedge clock);
    end
    bus.read = 1'b0;
    @(posedge clock);
    #1;
    n_tests++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got %b want 0", bus.readdatavalid);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic        v;
    logic        want;
    do_write(3'd4, 32'hCAFE_F00D, 4'hF);
    bus.read    = 1'b1;
    bus.address = 3'd4;
    for (int i = 0; i < 3; i++) begin
      reset = (i != 0);
      want  = (i == 0);
      @(posedge clock);
      #1;
      n_tests++;
      if (bus.readdatavalid !== want) begin
        n_fail++; $display("FAIL rst_mid_rdv[%0d]: got %b want %b", i, bus.readdatavalid, want);
      end
      @(negedge clock);
    end
    bus.read = 1'b0;
    reset    = 1'b0;
    m_scratch = 32'h0;
    m_irq_en  = 1'b0;
    @(posedge clock);
    #1;
    n_tests++;
    if (bus.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got %b want 0", bus.readdatavalid);
    end
    @(negedge clock);
    do_read(3'd4, d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_fail++; $display("FAIL rst_scratch: got v=%b d=%h want v=1 d=0", v, d);
    end
  endtask

`ifdef SYSID_UPTIME_EN
  task automatic test_uptime();
    logic [31:0] d;
    logic        v;
    apply_reset();
    repeat (40) @(negedge clock);
    do_read(3'd2, d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 32'(40 / DIV)) begin
      n_fail++; $display("FAIL uptime_lo40: got %0d want %0d", d, 40 / DIV);
    end
    // Shadow must hold the high word captured at the low-word read.
    force dut.uptime = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.uptime;
    do_read(3'd2, d, v);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL uptime_lo_pre: got %h want ffffffff", d);
    end
    repeat (DIV) @(negedge clock);
    do_read(3'd3, d, v);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL uptime_hi_shadow: got %h want 0", d);
    end
    force dut.uptime = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.uptime;
    repeat (DIV) @(negedge clock);
    do_read(3'd2, d, v);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL uptime_wrap_lo: got %h want 0", d);
    end
    do_read(3'd3, d, v);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL uptime_wrap_hi: got %h want 1", d);
    end
  endtask

  task automatic test_alarm();
    logic [31:0] m_alarm;
    logic        m_en, m_pend, hit;
    logic [2:0]  a;
    logic [31:0] wd;
    logic        wr;
    int unsigned up;
    apply_reset();
    m_alarm = 32'h0; m_en = 1'b0; m_pend = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      wr = 1'b1;
      case (k)
        1:       begin a = 3'd6; wd = 32'd5; end
        2:       begin a = 3'd7; wd = 32'h2; end
        25:      begin a = 3'd7; wd = 32'h3; end
        26:      begin a = 3'd6; wd = 32'd8; end
        32:      begin a = 3'd7; wd = 32'h3; end
        default: begin a = 3'd0; wd = 32'h0; wr = 1'b0; end
      endcase
      bus.address = a; bus.write = wr; bus.writedata = wd; bus.byteenable = 4'hF;
      @(posedge clock);
      #1;
      up  = int'(k) / DIV;
      hit = (int'(k) % DIV == 0) && (32'(up) == m_alarm);
      if (wr && a == 3'd6) m_alarm = wd;
      if (wr && a == 3'd7) begin
        m_en = wd[1];
        if (wd[0]) m_pend = 1'b0;
      end
      if (hit) m_pend = 1'b1;
      n_tests++;
      if (bus.irq !== (m_pend & m_en)) begin
        n_fail++; $display("FAIL alarm_irq[k=%0d]: got %b want %b", k, bus.irq, m_pend & m_en);
      end
      @(negedge clock);
    end
    bus_idle();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    caps_exp = (32'(DIV) << 16) | 32'(PRESENT);
    reset = 1'b1;
    bus_idle();
    test_reset();
    test_id_regs();
    test_scratch_lanes();
    test_random();
    test_back_to_back();
    test_reset_mid_read();
`ifdef SYSID_UPTIME_EN
    test_uptime();
    test_alarm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
